echo_scheduler: RTL and testbench

ECHO_SCHEDULER -- requirements
Module: echo_scheduler

---
 rtl/echo_scheduler.sv | 165 ++++++++++++++++
 tb/tb_echo_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : echo_scheduler                                               |
// | Description : Delay-line echo sequencer driving a single-port RAM with     |
// |               saturating feedback mix and full-memory clear sweep.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module echo_scheduler #(
  parameter int BITSIZE = 24,
  parameter int ADDRLEN = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [BITSIZE-1:0] sample_in,
  input  logic [ADDRLEN-1:0] delay,
  input  logic [2:0]         fb_shift,
  input  logic               clear_req,
  input  logic               clear_ovr,
  output logic [BITSIZE-1:0] sample_out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun,
  output logic [ADDRLEN-1:0] mem_addr,
  output logic [BITSIZE-1:0] mem_datain,
  output logic               mem_wren,
  input  logic [BITSIZE-1:0] mem_dataout
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [ADDRLEN-1:0] c_addr_max = '1;
  localparam logic [BITSIZE-1:0] c_sat_max  = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic [BITSIZE-1:0] c_sat_min  = {1'b1, {(BITSIZE-1){1'b0}}};

  state_t                     r_state, w_state_nxt;
  logic [ADDRLEN-1:0]         r_clr_cnt;
  logic [ADDRLEN-1:0]         r_wr_ptr;
  logic signed [BITSIZE-1:0]  r_sample_q;
  logic [ADDRLEN-1:0]         r_delay_q;
  logic [2:0]                 r_fb_q;
  logic signed [BITSIZE-1:0]  r_delayed_q;
  logic [BITSIZE-1:0]         r_sample_out;
  logic                       r_out_valid;
  logic                       r_overrun;

  logic                       w_accept;
  logic                       w_drop;
  logic                       w_clear_start;
  logic signed [BITSIZE-1:0]  w_shifted;
  logic [BITSIZE:0]           w_sum;
  logic [BITSIZE-1:0]         w_mix;
  logic [ADDRLEN-1:0]         w_mem_addr;
  logic [BITSIZE-1:0]         w_mem_datain;
  logic                       w_mem_wren;

  // clear_req has priority over a simultaneous sample, which is then dropped
  assign w_clear_start = (r_state == S_IDLE) && clear_req;
  assign w_accept      = (r_state == S_IDLE) && sample_valid && !clear_req;
  assign w_drop        = sample_valid && !w_accept;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == c_addr_max) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (clear_req)         w_state_nxt = S_CLEAR;
        else if (sample_valid) w_state_nxt = S_READ;
      end
      S_READ:  w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Feedback mix: 1-bit-wider signed sum, clamped back to BITSIZE
  assign w_shifted = r_delayed_q >>> r_fb_q;
  assign w_sum     = {r_sample_q[BITSIZE-1], r_sample_q} + {w_shifted[BITSIZE-1], w_shifted};

  always_comb begin
    w_mix = r_sample_q;
    if (r_fb_q != 3'd0) begin
      if (w_sum[BITSIZE] != w_sum[BITSIZE-1])
        w_mix = w_sum[BITSIZE] ? c_sat_min : c_sat_max;
      else
        w_mix = w_sum[BITSIZE-1:0];
    end
  end

  always_comb begin
    w_mem_addr   = '0;
    w_mem_datain = '0;
    w_mem_wren   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_mem_wren = 1'b1;
        w_mem_addr = r_clr_cnt;
      end
      S_READ:  w_mem_addr = r_wr_ptr - r_delay_q;
      S_WRITE: begin
        w_mem_wren   = 1'b1;
        w_mem_addr   = r_wr_ptr;
        w_mem_datain = w_mix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= '0;
      r_wr_ptr     <= '0;
      r_sample_q   <= '0;
      r_delay_q    <= '0;
      r_fb_q       <= 3'd0;
      r_delayed_q  <= '0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (r_state == S_WAIT);
      if (w_clear_start)
        r_clr_cnt <= '0;
      else if (r_state == S_CLEAR)
        r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_accept) begin
        r_sample_q <= sample_in;
        r_delay_q  <= delay;
        r_fb_q     <= fb_shift;
      end
      if (r_state == S_WAIT) begin
        r_delayed_q  <= mem_dataout;
        r_sample_out <= mem_dataout;
      end
      if (r_state == S_WRITE)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_drop)
        r_overrun <= 1'b1;
      else if (clear_ovr)
        r_overrun <= 1'b0;
    end
  end

  // Write enable is gated by reset so an in-flight write is cut immediately
  assign mem_wren   = w_mem_wren & rst_n;
  assign mem_addr   = w_mem_addr;
  assign mem_datain = w_mem_datain;
  assign sample_out = r_sample_out;
  assign out_valid  = r_out_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_echo_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_echo_scheduler                                            |
// | Description : Scoreboard bench for echo_scheduler with a registered-read   |
// |               RAM model, ADDRLEN=4, BITSIZE=24.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_echo_scheduler;

  localparam int B = 24;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sample_valid;
  logic [B-1:0] sample_in;
  logic [A-1:0] delay;
  logic [2:0]   fb_shift;
  logic         clear_req;
  logic         clear_ovr;
  logic [B-1:0] sample_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic [A-1:0] mem_addr;
  logic [B-1:0] mem_datain;
  logic         mem_wren;
  logic [B-1:0] mem_dataout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic preload = 1'b1;

  typedef struct {
    logic [B-1:0] out;
    logic [A-1:0] waddr;
    logic [B-1:0] wdata;
    int           cyc;
  } exp_t;

  exp_t sbq[$];

  echo_scheduler #(.BITSIZE(B), .ADDRLEN(A)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .delay        (delay),
    .fb_shift     (fb_shift),
    .clear_req    (clear_req),
    .clear_ovr    (clear_ovr),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .mem_addr     (mem_addr),
    .mem_datain   (mem_datain),
    .mem_wren     (mem_wren),
    .mem_dataout  (mem_dataout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SPRAM model: registered read, old data on read-during-write; preloaded with junk
  logic [B-1:0] mem [16];
  logic [B-1:0] rd_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 24'h0A0000 + B'(i);
      rd_q <= '0;
    end else begin
      rd_q <= mem[mem_addr];
      if (mem_wren) mem[mem_addr] <= mem_datain;
    end
  end
  assign mem_dataout = rd_q;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Monitor: every out_valid pops one expected transaction
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0h required=none", sample_out);
      end else begin
        e = sbq.pop_front();
        chk("sample_out", 32'(sample_out), 32'(e.out));
        chk("latency_cyc", 32'(cyc), 32'(e.cyc));
        chk("wr_wren", 32'(mem_wren), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'(e.waddr));
        chk("wr_data", 32'(mem_datain), 32'(e.wdata));
      end
    end
  end

  task automatic send(input logic [B-1:0] s, input logic [A-1:0] d, input logic [2:0] f,
                      input logic [B-1:0] eo, input logic [A-1:0] ra, input logic [A-1:0] wa,
                      input logic [B-1:0] wd, input bit drop);
    exp_t e;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = s;
    delay        = d;
    fb_shift     = f;
    e.out   = eo;
    e.waddr = wa;
    e.wdata = wd;
    e.cyc   = cyc + 3;
    sbq.push_back(e);
    @(negedge clk);
    sample_valid = 1'b0;
    sample_in    = 24'hFFFFFF;
    delay        = 4'hF;
    fb_shift     = 3'd7;
    chk("rd_addr", 32'(mem_addr), 32'(ra));
    chk("rd_wren", 32'(mem_wren), 32'd0);
    @(negedge clk);
    if (drop) begin
      sample_valid = 1'b1;
      sample_in    = 24'h123456;
      clear_ovr    = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    clear_ovr    = 1'b0;
    if (drop) chk("overrun_set", 32'(overrun), 32'd1);
  endtask

  task automatic check_sweep();
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_wren", 32'(mem_wren), 32'd1);
      chk("clr_addr", 32'(mem_addr), 32'(i));
      chk("clr_data", 32'(mem_datain), 32'd0);
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_wren", 32'(mem_wren), 32'd0);
    chk("idle_addr", 32'(mem_addr), 32'd0);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    delay        = '0;
    fb_shift     = 3'd0;
    clear_req    = 1'b0;
    clear_ovr    = 1'b0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep();

    // Plain delay line, delay=3
    send(24'd1, 4'd3, 3'd0, 24'd0, 4'd13, 4'd0, 24'd1, 1'b0);
    send(24'd2, 4'd3, 3'd0, 24'd0, 4'd14, 4'd1, 24'd2, 1'b0);
    send(24'd3, 4'd3, 3'd0, 24'd0, 4'd15, 4'd2, 24'd3, 1'b0);
    send(24'd4, 4'd3, 3'd0, 24'd1, 4'd0,  4'd3, 24'd4, 1'b0);
    send(24'd5, 4'd3, 3'd0, 24'd2, 4'd1,  4'd4, 24'd5, 1'b0);

    // Pointer wrap: 20 samples starting at wr_ptr=5 (k=12 writes 1, reads 14)
    for (int k = 0; k < 20; k++) begin
      logic [A-1:0] p;
      p = A'(5 + k);
      send(24'd100 + B'(k), 4'd3, 3'd0, (k >= 3) ? 24'd97 + B'(k) : 24'd3 + B'(k),
           p - 4'd3, p, 24'd100 + B'(k), 1'b0);
    end

    // Feedback and saturation, wr_ptr=9
    send(24'h7FFFFE, 4'd1, 3'd0, 24'd119,    4'd8,  4'd9,  24'h7FFFFE, 1'b0);
    send(24'h7FFFFE, 4'd1, 3'd1, 24'h7FFFFE, 4'd9,  4'd10, 24'h7FFFFF, 1'b0);
    send(24'h800001, 4'd1, 3'd0, 24'h7FFFFF, 4'd10, 4'd11, 24'h800001, 1'b0);
    send(24'h800000, 4'd1, 3'd1, 24'h800001, 4'd11, 4'd12, 24'h800000, 1'b0);
    send(24'h000010, 4'd2, 3'd2, 24'h800001, 4'd11, 4'd13, 24'hE00010, 1'b0);

    // delay=0 reads the slot about to be overwritten
    send(24'h000055, 4'd0, 3'd0, 24'd109, 4'd14, 4'd14, 24'h000055, 1'b0);

    // clear_req beats a simultaneous sample; wr_ptr survives the sweep
    @(negedge clk);
    clear_req    = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 24'd77;
    @(negedge clk);
    clear_req    = 1'b0;
    sample_valid = 1'b0;
    chk("clrreq_overrun", 32'(overrun), 32'd1);
    chk("clrreq_wren", 32'(mem_wren), 32'd1);
    chk("clrreq_addr", 32'(mem_addr), 32'd0);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    n = 1;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("clrreq_busy_cycles", 32'(n), 32'd16);
    send(24'h000066, 4'd1, 3'd0, 24'd0, 4'd14, 4'd15, 24'h000066, 1'b0);

    // Drop two cycles after acceptance, coincident with clear_ovr
    send(24'h000077, 4'd3, 3'd0, 24'd0, 4'd13, 4'd0, 24'h000077, 1'b1);
    repeat (3) @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    chk("overrun_clear", 32'(overrun), 32'd0);
    send(24'h000088, 4'd1, 3'd0, 24'h000077, 4'd0, 4'd1, 24'h000088, 1'b0);

    // Reset asserted mid-transaction during WAIT
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 24'd99;
    delay        = 4'd1;
    fb_shift     = 3'd0;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sample_out", 32'(sample_out), 32'd0);
    chk("midrst_wren", 32'(mem_wren), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep();
    send(24'h0000AB, 4'd0, 3'd0, 24'd0, 4'd0, 4'd0, 24'h0000AB, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
